einstein_keymatrix: RTL and testbench
=====================================

# einstein_keymatrix

Keyboard responder for the Tatung Einstein core: decodes a host PS/2 keyboard stream into an 8×8 key-down matrix plus SHIFT/CTRL/GRAPH lines. Row select comes from the PSG's port A output. The block answers with column data on the PSG's port B input, i.e. it is the matrix end of the scan interface the firmware drives. It also feeds the modifier bits read back through the keyboard-mask port.

## Interface
Parameters:
- FILTER_LEN, 8: clk_sys samples a PS/2 line must hold a level before it is accepted.
- TIMEOUT, 65536: clk_sys cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk_sys  in  1  system clock, 20 MHz.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from the host; asynchronous.
- ps2_data  in  1  raw PS/2 data from the host; asynchronous.
- kb_row  in  8  active-low row select; bit r low = row r scanned.
- kb_col  out  8  active-low column return; bit c low = a pressed key in a selected row at column c.
- kb_shift  out  1  active-low; low while left or right shift is held.
- kb_ctrl  out  1  active-low; low while ctrl is held.
- kb_graph  out  1  active-low; low while left alt or right alt (E0 11) is held.
- frame_err  out  1  one-cycle pulse on a start, parity or stop error, or on a timeout.

## Operation
- Line conditioning:
  - Each PS/2 line passes through a 2-FF synchroniser.
  - A level is accepted after FILTER_LEN identical consecutive samples.
  - A filtered ps2_clk 1→0 transition is a bit strobe.
- Frame receiver FSM:
  - States: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with data=0 go to DATA, else raise frame_err and stay in IDLE.
  - DATA: shift 8 bits LSB first.
  - PARITY: check odd parity.
  - STOP: require data=1, then emit byte_valid plus the byte.
  - Any error: frame_err, return to IDLE, clear the prefix flags.
- Timeout: in any state except IDLE, a count reaching TIMEOUT-1 since the last strobe gives frame_err and forces IDLE.
- Prefix decode:
  - E0 sets ext; F0 sets rel.
  - Any other byte is looked up with index {ext, code}; make when rel=0, break when rel=1. Both flags then clear.
  - E1 and every unmapped code are ignored, but they still clear the flags.
- Keymap entry format: {valid, kind[1:0], row[2:0], col[2:0]}. kind = matrix, shift, ctrl or graph.
- State:
  - Matrix: 64-bit key_down[row*8+col].
  - Modifiers: four bits (lshift, rshift, ctrl, graph).
  - Two scancodes that map to the same cell share one bit; the last event wins.
- Outputs:
  - kb_col[c] = ~|{ key_down[r*8+c] & ~kb_row[r] } over r = 0..7. Combinational from kb_row; multiple low rows OR together.
  - kb_shift = ~(lshift|rshift); kb_ctrl = ~ctrl; kb_graph = ~graph.
- Fixed map entries the bench relies on:
  - 1C (A) → row 2 col 0.
  - 29 (space) → row 0 col 0.
  - 5A (return) → row 0 col 7.
  - E0 75 (up) → row 6 col 3.
  - 12/59 → shift; 14 → ctrl; 11 and E0 11 → graph.

## Timing
- Reset values:
  - key_down = 0, modifiers = 0.
  - kb_col = FF, kb_shift = kb_ctrl = kb_graph = 1.
  - frame_err = 0; FSM in IDLE, flags clear.
  - Filter outputs reset to 1 (idle bus).
- Latency: byte_valid registers 1 cycle after the stop-bit strobe. The matrix/modifier update registers on the following cycle. kb_col changes in the same cycle as that update.
- kb_row → kb_col: zero cycles (combinational), so the PSG samples its port B inside one read.
- Reset mid-frame: the FSM aborts to IDLE with no frame_err.
- Strobe at the exact cycle the timeout expires: the timeout wins, and the strobe is discarded.

## Structure
- Package einstein_kb_pkg holds:
  - keymap entry typedef and kind enum;
  - keymap_lookup(ext, code) function covering the full Einstein layout;
  - prefix constants E0/F0/E1 and FSM state enum.
- Sub-module ps2_rx: synchroniser, filter, frame FSM and timeout, with outputs byte_valid, byte and frame_err.
- Top level: prefix logic, state registers, column mux.

## Test plan
- Send 1C → kb_row=FB gives kb_col=FE; kb_row=FF gives FF. Then send F0 1C → kb_col=FF on kb_row=FB.
- Hold A and space; kb_row=FA → kb_col=FE. kb_row=FE → FE; kb_row=FB → FE; kb_row=F7 → FF.
- E0 75 → row 6 col 3 set: kb_row=BF gives kb_col=F7. Send 75 without the prefix → no matrix change.
- Send 12 then 59, then F0 12 → kb_shift stays 0. Then F0 59 → kb_shift=1. Send 14 → kb_ctrl=0; send E0 11 → kb_graph=0.
- Frame with bad parity for 1C → frame_err pulse, matrix unchanged. Next valid 1C is accepted.
- Send 5 bits, then idle for TIMEOUT cycles → frame_err pulse. A following full 5A frame gives kb_col=7F on kb_row=FE.
- Assert reset while keys are held → all outputs return to reset values within one cycle.

Source files
------------

// File: rtl/einstein_kb_pkg.sv
// Shared types for the Einstein keyboard responder: keymap entries,
// PS/2 prefix bytes, receiver states and the scancode lookup.
package einstein_kb_pkg;

  localparam logic [7:0] KB_E0 = 8'hE0;
  localparam logic [7:0] KB_F0 = 8'hF0;
  localparam logic [7:0] KB_E1 = 8'hE1;

  typedef enum logic [1:0] {
    K_MATRIX,
    K_SHIFT,
    K_CTRL,
    K_GRAPH
  } kb_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic       valid;
    kb_kind_e   kind;
    logic [2:0] row;
    logic [2:0] col;
  } kb_ent_t;

  function automatic kb_ent_t km(kb_kind_e k, int r, int c);
    kb_ent_t e;
    e.valid = 1'b1;
    e.kind  = k;
    e.row   = 3'(r);
    e.col   = 3'(c);
    return e;
  endfunction

  // Index is {ext, code}; E1 and anything absent map to an invalid entry.
  // Shift entries use col 0 for left, col 1 for right.
  function automatic kb_ent_t keymap_lookup(logic ext, logic [7:0] code);
    kb_ent_t e;
    e = '0;
    case ({ext, code})
      9'h029: e = km(K_MATRIX, 0, 0);
      9'h066: e = km(K_MATRIX, 0, 1);
      9'h00D: e = km(K_MATRIX, 0, 2);
      9'h076: e = km(K_MATRIX, 0, 3);
      9'h05A: e = km(K_MATRIX, 0, 7);
      9'h016: e = km(K_MATRIX, 1, 0);
      9'h01E: e = km(K_MATRIX, 1, 1);
      9'h026: e = km(K_MATRIX, 1, 2);
      9'h025: e = km(K_MATRIX, 1, 3);
      9'h02E: e = km(K_MATRIX, 1, 4);
      9'h036: e = km(K_MATRIX, 1, 5);
      9'h03D: e = km(K_MATRIX, 1, 6);
      9'h03E: e = km(K_MATRIX, 1, 7);
      9'h01C: e = km(K_MATRIX, 2, 0);
      9'h032: e = km(K_MATRIX, 2, 1);
      9'h021: e = km(K_MATRIX, 2, 2);
      9'h023: e = km(K_MATRIX, 2, 3);
      9'h024: e = km(K_MATRIX, 2, 4);
      9'h02B: e = km(K_MATRIX, 2, 5);
      9'h034: e = km(K_MATRIX, 2, 6);
      9'h033: e = km(K_MATRIX, 2, 7);
      9'h043: e = km(K_MATRIX, 3, 0);
      9'h03B: e = km(K_MATRIX, 3, 1);
      9'h042: e = km(K_MATRIX, 3, 2);
      9'h04B: e = km(K_MATRIX, 3, 3);
      9'h03A: e = km(K_MATRIX, 3, 4);
      9'h031: e = km(K_MATRIX, 3, 5);
      9'h044: e = km(K_MATRIX, 3, 6);
      9'h04D: e = km(K_MATRIX, 3, 7);
      9'h015: e = km(K_MATRIX, 4, 0);
      9'h02D: e = km(K_MATRIX, 4, 1);
      9'h01B: e = km(K_MATRIX, 4, 2);
      9'h02C: e = km(K_MATRIX, 4, 3);
      9'h03C: e = km(K_MATRIX, 4, 4);
      9'h02A: e = km(K_MATRIX, 4, 5);
      9'h01D: e = km(K_MATRIX, 4, 6);
      9'h022: e = km(K_MATRIX, 4, 7);
      9'h035: e = km(K_MATRIX, 5, 0);
      9'h01A: e = km(K_MATRIX, 5, 1);
      9'h046: e = km(K_MATRIX, 5, 2);
      9'h045: e = km(K_MATRIX, 5, 3);
      9'h04E: e = km(K_MATRIX, 5, 4);
      9'h055: e = km(K_MATRIX, 5, 5);
      9'h041: e = km(K_MATRIX, 5, 6);
      9'h049: e = km(K_MATRIX, 5, 7);
      9'h04A: e = km(K_MATRIX, 6, 0);
      9'h04C: e = km(K_MATRIX, 6, 1);
      9'h052: e = km(K_MATRIX, 6, 2);
      9'h175: e = km(K_MATRIX, 6, 3);
      9'h172: e = km(K_MATRIX, 6, 4);
      9'h16B: e = km(K_MATRIX, 6, 5);
      9'h174: e = km(K_MATRIX, 6, 6);
      9'h054: e = km(K_MATRIX, 6, 7);
      9'h05B: e = km(K_MATRIX, 7, 0);
      9'h05D: e = km(K_MATRIX, 7, 1);
      9'h005: e = km(K_MATRIX, 7, 2);
      9'h006: e = km(K_MATRIX, 7, 3);
      9'h004: e = km(K_MATRIX, 7, 4);
      9'h00C: e = km(K_MATRIX, 7, 5);
      9'h058: e = km(K_MATRIX, 7, 6);
      9'h00E: e = km(K_MATRIX, 7, 7);
      9'h012: e = km(K_SHIFT, 0, 0);
      9'h059: e = km(K_SHIFT, 0, 1);
      9'h014: e = km(K_CTRL, 0, 0);
      9'h114: e = km(K_CTRL, 0, 0);
      9'h011: e = km(K_GRAPH, 0, 0);
      9'h111: e = km(K_GRAPH, 0, 0);
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: sync + glitch filter, frame FSM, timeout.
// Out: o_byte_valid/o_byte per frame, o_frame_err pulse on error.
module ps2_rx
  import einstein_kb_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65536
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  // bit 0 = clock line, bit 1 = data line
  logic [1:0]         r_s1, r_s2, r_filt;
  logic [1:0][FW-1:0] r_fcnt;
  logic               r_clk_d;
  rx_state_e          r_state, w_nstate;
  logic [7:0]         r_sh, w_nsh;
  logic [2:0]         r_bit, w_nbit;
  logic [TW-1:0]      r_tcnt;
  logic               w_strobe, w_data;
  logic               w_valid, w_err, w_tout;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_s1    <= 2'b11;
      r_s2    <= 2'b11;
      r_filt  <= 2'b11;
      r_fcnt  <= '0;
      r_clk_d <= 1'b1;
    end else begin
      r_s1    <= {i_ps2_data, i_ps2_clk};
      r_s2    <= r_s1;
      r_clk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_strobe = r_clk_d & ~r_filt[0];
  assign w_data   = r_filt[1];
  assign w_tout   = (r_state != ST_IDLE) &&
                    (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_nstate = r_state;
    w_nsh    = r_sh;
    w_nbit   = r_bit;
    w_valid  = 1'b0;
    w_err    = 1'b0;
    // timeout has priority; a coincident strobe is dropped
    if (w_tout) begin
      w_err    = 1'b1;
      w_nstate = ST_IDLE;
    end else if (w_strobe) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_data) begin
            w_nstate = ST_DATA;
            w_nbit   = 3'd0;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_DATA: begin
          w_nsh  = {w_data, r_sh[7:1]};
          w_nbit = r_bit + 3'd1;
          if (r_bit == 3'd7) w_nstate = ST_PARITY;
        end
        ST_PARITY: begin
          if (^{r_sh, w_data}) begin
            w_nstate = ST_STOP;
          end else begin
            w_err    = 1'b1;
            w_nstate = ST_IDLE;
          end
        end
        ST_STOP: begin
          w_nstate = ST_IDLE;
          if (w_data) w_valid = 1'b1;
          else        w_err   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sh         <= '0;
      r_bit        <= '0;
      r_tcnt       <= '0;
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_sh         <= w_nsh;
      r_bit        <= w_nbit;
      o_byte_valid <= w_valid;
      o_frame_err  <= w_err;
      if (w_valid) o_byte <= r_sh;
      if (r_state == ST_IDLE || w_strobe || w_tout)
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/einstein_keymatrix.sv
// Einstein keyboard matrix: PS/2 bytes -> 8x8 key matrix + modifiers.
// In: ps2_clk/ps2_data, kb_row. Out: kb_col, kb_shift/ctrl/graph, frame_err.
module einstein_keymatrix
  import einstein_kb_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65536
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] kb_row,
  output logic [7:0] kb_col,
  output logic       kb_shift,
  output logic       kb_ctrl,
  output logic       kb_graph,
  output logic       frame_err
);

  logic        w_bv;
  logic [7:0]  w_byte;
  logic        w_err;
  kb_ent_t     w_ent;
  logic        r_ext, r_rel;
  logic [63:0] r_key;
  logic        r_lsh, r_rsh, r_ctrl, r_graph;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_byte_valid(w_bv),
    .o_byte      (w_byte),
    .o_frame_err (w_err)
  );

  assign w_ent     = keymap_lookup(r_ext, w_byte);
  assign frame_err = w_err;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ext   <= 1'b0;
      r_rel   <= 1'b0;
      r_key   <= '0;
      r_lsh   <= 1'b0;
      r_rsh   <= 1'b0;
      r_ctrl  <= 1'b0;
      r_graph <= 1'b0;
    end else if (w_err) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (w_bv) begin
      if (w_byte == KB_E0) begin
        r_ext <= 1'b1;
      end else if (w_byte == KB_F0) begin
        r_rel <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
        if (w_ent.valid) begin
          unique case (w_ent.kind)
            K_MATRIX: r_key[{w_ent.row, w_ent.col}] <= ~r_rel;
            K_SHIFT: begin
              if (w_ent.col[0]) r_rsh <= ~r_rel;
              else              r_lsh <= ~r_rel;
            end
            K_CTRL:  r_ctrl  <= ~r_rel;
            K_GRAPH: r_graph <= ~r_rel;
          endcase
        end
      end
    end
  end

  always_comb begin
    kb_col = 8'hFF;
    for (int r = 0; r < 8; r++)
      kb_col = kb_col & ~(r_key[r*8 +: 8] & {8{~kb_row[r]}});
  end

  assign kb_shift = ~(r_lsh | r_rsh);
  assign kb_ctrl  = ~r_ctrl;
  assign kb_graph = ~r_graph;

endmodule

// File: tb/tb_einstein_keymatrix.sv
// Scoreboard bench for einstein_keymatrix: PS/2 frames in,
// queued expectations on kb_col/modifiers/frame_err drained after.
module tb_einstein_keymatrix;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] kb_row;
  logic [7:0] kb_col;
  logic       kb_shift, kb_ctrl, kb_graph, frame_err;

  int n_chk  = 0;
  int n_pass = 0;
  int err_cnt  = 0;
  int err_mark = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] row;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  einstein_keymatrix #(
    .FILTER_LEN(8),
    .TIMEOUT   (1024)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb_row   (kb_row),
    .kb_col   (kb_col),
    .kb_shift (kb_shift),
    .kb_ctrl  (kb_ctrl),
    .kb_graph (kb_graph),
    .frame_err(frame_err)
  );

  always #25 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if (frame_err === 1'b1) err_cnt++;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // sel: 0 kb_col, 1 shift, 2 ctrl, 3 graph, 4 err delta,
  // 5 any err since mark, 6 frame_err level
  task automatic want(string tag, int sel, logic [7:0] row,
                      logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.row = row;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk_sys);
      kb_row = e.row;
      #1;
      case (e.sel)
        0:       got = kb_col;
        1:       got = {7'd0, kb_shift};
        2:       got = {7'd0, kb_ctrl};
        3:       got = {7'd0, kb_graph};
        4:       got = 8'(err_cnt - err_mark);
        5:       got = {7'd0, err_cnt != err_mark};
        default: got = {7'd0, frame_err};
      endcase
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (20) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad = 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad);
    ps2_bit(1'b1);
    repeat (30) @(negedge clk_sys);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    kb_row   = 8'hFF;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);

    want("rst_col", 0, 8'h00, 8'hFF);
    want("rst_shift", 1, 8'h00, 8'h01);
    want("rst_ctrl", 2, 8'h00, 8'h01);
    want("rst_graph", 3, 8'h00, 8'h01);
    want("rst_ferr", 6, 8'h00, 8'h00);
    drain();

    err_mark = err_cnt;
    send(8'h1C);
    want("a_row2", 0, 8'hFB, 8'hFE);
    want("a_norow", 0, 8'hFF, 8'hFF);
    drain();
    send(8'hF0); send(8'h1C);
    want("a_rel", 0, 8'hFB, 8'hFF);
    drain();

    send(8'h1C); send(8'h29);
    want("as_fa", 0, 8'hFA, 8'hFE);
    want("as_fe", 0, 8'hFE, 8'hFE);
    want("as_fb", 0, 8'hFB, 8'hFE);
    want("as_f7", 0, 8'hF7, 8'hFF);
    drain();

    send(8'hE0); send(8'h75);
    want("up_set", 0, 8'hBF, 8'hF7);
    drain();
    send(8'h75);
    want("up_noext", 0, 8'hBF, 8'hF7);
    want("all_rows", 0, 8'h00, 8'hF6);
    drain();

    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    want("shift_r", 1, 8'hFF, 8'h00);
    drain();
    send(8'hF0); send(8'h59);
    want("shift_off", 1, 8'hFF, 8'h01);
    drain();
    send(8'h14);
    want("ctrl_on", 2, 8'hFF, 8'h00);
    send(8'hE0); send(8'h11);
    want("graph_on", 3, 8'hFF, 8'h00);
    want("no_err", 4, 8'hFF, 8'h00);
    drain();

    send(8'hF0); send(8'h1C);
    err_mark = err_cnt;
    send(8'h1C, 1'b1);
    want("par_err", 5, 8'hFF, 8'h01);
    want("par_keep", 0, 8'hFB, 8'hFF);
    drain();
    send(8'h1C);
    want("par_next", 0, 8'hFB, 8'hFE);
    drain();

    send(8'hF0); send(8'h29);
    err_mark = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (1200) @(negedge clk_sys);
    want("tout_err", 4, 8'hFF, 8'h01);
    drain();
    send(8'h5A);
    want("ret_col", 0, 8'hFE, 8'h7F);
    drain();

    @(negedge clk_sys);
    reset = 1'b1;
    want("rr_col", 0, 8'h00, 8'hFF);
    want("rr_shift", 1, 8'h00, 8'h01);
    want("rr_ctrl", 2, 8'h00, 8'h01);
    want("rr_graph", 3, 8'h00, 8'h01);
    want("rr_ferr", 6, 8'h00, 8'h00);
    drain();
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
